// File: rtl/spwm_decoder_pkg.sv
// rtl/spwm_decoder_pkg.sv - shared SPWM table lengths, widths and decoder state encodings
package spwm_decoder_pkg;

    // Table lengths shared with the SPWM generator so both link ends agree.
    localparam int TRI_STEPS        = 50;
    localparam int SIN_STEPS        = 1000;
    localparam int SAMPLES_PER_SINE = SIN_STEPS / TRI_STEPS;

    // Duty/window counter holds TRI_STEPS * 65535.
    localparam int CNT_W      = 22;
    localparam int CYC_W      = 16;
    localparam int STEP_W     = 6;
    localparam int IDX_W      = 5;

    // Stable clocks required by the optional glitch filter.
    localparam int GLITCH_LEN = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } dec_state_e;

endpackage

// File: rtl/spwm_decoder_in_filter.sv
// rtl/spwm_decoder_in_filter.sv - 2-FF synchroniser plus optional glitch filter (SPWM_DEC_GLITCH_FILTER_EN)
module spwm_decoder_in_filter
    import spwm_decoder_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic spwm_in,
    output logic in_s
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    // Two-stage synchroniser for the asynchronous pin.
    always_comb begin
        sync1_d = spwm_in;
        sync2_d = sync1_q;
    end

    // Synchroniser registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef SPWM_DEC_GLITCH_FILTER_EN
    localparam int GCNT_W = $clog2(GLITCH_LEN + 1);

    logic              filt_q, filt_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;

    // Accept a new level only after it has been seen GLITCH_LEN clocks in a row.
    always_comb begin
        filt_d = filt_q;
        gcnt_d = gcnt_q;
        if (sync2_q == filt_q) begin
            gcnt_d = '0;
        end else if (gcnt_q == GCNT_W'(GLITCH_LEN - 1)) begin
            filt_d = sync2_q;
            gcnt_d = '0;
        end else begin
            gcnt_d = gcnt_q + GCNT_W'(1);
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            gcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            gcnt_q <= gcnt_d;
        end
    end

    assign in_s = filt_q;
`else
    assign in_s = sync2_q;
`endif

endmodule

// File: rtl/spwm_decoder.sv
// rtl/spwm_decoder.sv - SPWM receive decoder, one duty sample per carrier window (SPWM_DEC_GLITCH_FILTER_EN optional)
module spwm_decoder
    import spwm_decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             refresh,
    input  logic [CYC_W-1:0] cycle,
    input  logic             spwm_in,
    output logic [CNT_W-1:0] duty,
    output logic             duty_valid,
    output logic [IDX_W-1:0] sample_idx,
    output logic             sine_start,
    output logic             los
);

    logic in_s;

    spwm_decoder_in_filter u_in_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .spwm_in (spwm_in),
        .in_s    (in_s)
    );

    dec_state_e       state_q, state_d;
    logic [CYC_W-1:0] cycle_q, cycle_d;
    logic [CYC_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic             edge_seen_q, edge_seen_d;
    logic             in_prev_q, in_prev_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             duty_valid_q, duty_valid_d;
    logic [IDX_W-1:0] sample_idx_q, sample_idx_d;
    logic             sine_start_q, sine_start_d;
    logic             los_q, los_d;

    logic edge_now;
    logic clk_wrap;
    logic step_wrap;
    logic win_end;

    // Next-state: refresh restarts everything but duty/los; the window end emits a sample.
    always_comb begin
        state_d      = state_q;
        cycle_d      = cycle_q;
        clk_cnt_d    = clk_cnt_q;
        step_cnt_d   = step_cnt_q;
        high_cnt_d   = high_cnt_q;
        edge_seen_d  = edge_seen_q;
        idx_d        = idx_q;
        duty_d       = duty_q;
        duty_valid_d = 1'b0;
        sample_idx_d = sample_idx_q;
        sine_start_d = 1'b0;
        los_d        = los_q;

        in_prev_d = in_s;
        edge_now  = in_s ^ in_prev_q;
        clk_wrap  = (clk_cnt_q == (cycle_q - CYC_W'(1)));
        step_wrap = (step_cnt_q == STEP_W'(TRI_STEPS - 1));
        win_end   = (state_q == ST_RUN) && clk_wrap && step_wrap;

        if (refresh) begin
            cycle_d      = cycle;
            state_d      = (cycle != '0) ? ST_RUN : ST_IDLE;
            clk_cnt_d    = '0;
            step_cnt_d   = '0;
            high_cnt_d   = '0;
            edge_seen_d  = 1'b0;
            idx_d        = '0;
            sample_idx_d = '0;
        end else if (state_q == ST_IDLE) begin
            clk_cnt_d   = '0;
            step_cnt_d  = '0;
            high_cnt_d  = '0;
            edge_seen_d = 1'b0;
        end else if (win_end) begin
            clk_cnt_d    = '0;
            step_cnt_d   = '0;
            high_cnt_d   = '0;
            edge_seen_d  = 1'b0;
            duty_d       = high_cnt_q + CNT_W'(in_s);
            duty_valid_d = 1'b1;
            sample_idx_d = idx_q;
            sine_start_d = (idx_q == '0);
            los_d        = ~(edge_seen_q | edge_now);
            idx_d        = (idx_q == IDX_W'(SAMPLES_PER_SINE - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            if (clk_wrap) begin
                clk_cnt_d  = '0;
                step_cnt_d = step_cnt_q + STEP_W'(1);
            end else begin
                clk_cnt_d = clk_cnt_q + CYC_W'(1);
            end
            high_cnt_d  = high_cnt_q + CNT_W'(in_s);
            edge_seen_d = edge_seen_q | edge_now;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cycle_q      <= '0;
            clk_cnt_q    <= '0;
            step_cnt_q   <= '0;
            high_cnt_q   <= '0;
            edge_seen_q  <= 1'b0;
            in_prev_q    <= 1'b0;
            idx_q        <= '0;
            duty_q       <= '0;
            duty_valid_q <= 1'b0;
            sample_idx_q <= '0;
            sine_start_q <= 1'b0;
            los_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cycle_q      <= cycle_d;
            clk_cnt_q    <= clk_cnt_d;
            step_cnt_q   <= step_cnt_d;
            high_cnt_q   <= high_cnt_d;
            edge_seen_q  <= edge_seen_d;
            in_prev_q    <= in_prev_d;
            idx_q        <= idx_d;
            duty_q       <= duty_d;
            duty_valid_q <= duty_valid_d;
            sample_idx_q <= sample_idx_d;
            sine_start_q <= sine_start_d;
            los_q        <= los_d;
        end
    end

    assign duty       = duty_q;
    assign duty_valid = duty_valid_q;
    assign sample_idx = sample_idx_q;
    assign sine_start = sine_start_q;
    assign los        = los_q;

endmodule
